biriscv_trace_gen: RTL and testbench

Retire-side trace generator for the dual-issue core: captures up to two committed instructions per cycle from the writeback stage in program order, buffers them, and emits one `{pc, opcode}` record per cycle on a single-lane valid/accept stream. That stream is the producer side of the simulation trace decoder's `valid`/`pc`/`opcode` input, and can also feed an external trace port. Overflow is lossy and flagged; the pipeline is never stalled.

---
 rtl/biriscv_trace_gen.sv | 98 +++++++++
 tb/tb_biriscv_trace_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/biriscv_trace_gen.sv
// Retire-side trace generator: buffers up to two retired {pc, opcode} records per cycle
// and emits one per cycle. Optional drop counter enabled by BIRISCV_TRACE_DROPCNT_EN.
module biriscv_trace_gen #(
   parameter int DEPTH   = 8,
   parameter int DEPTH_W = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               ret0_valid_i,
   input  logic [31:0]        ret0_pc_i,
   input  logic [31:0]        ret0_opcode_i,
   input  logic               ret1_valid_i,
   input  logic [31:0]        ret1_pc_i,
   input  logic [31:0]        ret1_opcode_i,
   output logic               valid_o,
   output logic [31:0]        pc_o,
   output logic [31:0]        opcode_o,
   input  logic               accept_i,
   output logic [DEPTH_W:0]   level_o,
   output logic               overflow_o,
   output logic [15:0]        drop_count_o
);

   logic [63:0]        r_mem [DEPTH];
   logic [DEPTH_W-1:0] r_wr_ptr;
   logic [DEPTH_W-1:0] r_rd_ptr;
   logic [DEPTH_W:0]   r_count;
   logic               r_overflow;

   logic [1:0]         w_n;
   logic [DEPTH_W:0]   w_free;
   logic               w_push;
   logic               w_drop;
   logic               w_pop;
   logic [DEPTH_W-1:0] w_slot1_ptr;
   logic [DEPTH_W:0]   w_count_nxt;

   // Free space ignores a same-cycle pop so the push decision never depends on accept_i.
   assign w_n         = {1'b0, ret0_valid_i} + {1'b0, ret1_valid_i};
   assign w_free      = (DEPTH_W+1)'(DEPTH) - r_count;
   assign w_push      = (w_n != 2'd0) && ((DEPTH_W+1)'(w_n) <= w_free);
   assign w_drop      = (w_n != 2'd0) && !w_push;
   assign w_pop       = (r_count != '0) && accept_i;
   assign w_slot1_ptr = ret0_valid_i ? (r_wr_ptr + DEPTH_W'(1)) : r_wr_ptr;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push) w_count_nxt = w_count_nxt + (DEPTH_W+1)'(w_n);
      if (w_pop)  w_count_nxt = w_count_nxt - (DEPTH_W+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         if (ret0_valid_i) r_mem[r_wr_ptr]    <= {ret0_pc_i, ret0_opcode_i};
         if (ret1_valid_i) r_mem[w_slot1_ptr] <= {ret1_pc_i, ret1_opcode_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_W'(w_n);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_W'(1);
         r_count <= w_count_nxt;
         if (w_drop) r_overflow <= 1'b1;
      end
   end

`ifdef BIRISCV_TRACE_DROPCNT_EN
   logic [15:0] r_drop_cnt;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {15'd0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i)       r_drop_cnt <= '0;
      else if (w_drop) r_drop_cnt <= sat_add16(r_drop_cnt, w_n);
   end

   assign drop_count_o = r_drop_cnt;
`else
   assign drop_count_o = '0;
`endif

   assign valid_o    = (r_count != '0);
   assign pc_o       = r_mem[r_rd_ptr][63:32];
   assign opcode_o   = r_mem[r_rd_ptr][31:0];
   assign level_o    = r_count;
   assign overflow_o = r_overflow;

endmodule

// File: tb/tb_biriscv_trace_gen.sv
// Directed self-checking bench for biriscv_trace_gen (DEPTH=8).
module tb_biriscv_trace_gen;
   logic        clk = 1'b0;
   logic        rst_i;
   logic        ret0_valid_i, ret1_valid_i;
   logic [31:0] ret0_pc_i, ret0_opcode_i, ret1_pc_i, ret1_opcode_i;
   logic        valid_o, accept_i, overflow_o;
   logic [31:0] pc_o, opcode_o;
   logic [3:0]  level_o;
   logic [15:0] drop_count_o;

   int vectors = 0;
   int miscompares = 0;

`ifdef BIRISCV_TRACE_DROPCNT_EN
   localparam logic [15:0] DROP2 = 16'd2;
`else
   localparam logic [15:0] DROP2 = 16'd0;
`endif

   biriscv_trace_gen #(.DEPTH(8), .DEPTH_W(3)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .ret0_valid_i(ret0_valid_i), .ret0_pc_i(ret0_pc_i), .ret0_opcode_i(ret0_opcode_i),
      .ret1_valid_i(ret1_valid_i), .ret1_pc_i(ret1_pc_i), .ret1_opcode_i(ret1_opcode_i),
      .valid_o(valid_o), .pc_o(pc_o), .opcode_o(opcode_o), .accept_i(accept_i),
      .level_o(level_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      ret0_valid_i = 0; ret1_valid_i = 0;
      ret0_pc_i = '0; ret0_opcode_i = '0; ret1_pc_i = '0; ret1_opcode_i = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst_i = 1; tick(); rst_i = 0;
   endtask

   // One cycle of retires, then inputs return to idle.
   task automatic retire(input logic v0, input logic [31:0] pc0, input logic v1, input logic [31:0] pc1);
      ret0_valid_i = v0; ret0_pc_i = pc0; ret0_opcode_i = pc0 ^ 32'h5A000000;
      ret1_valid_i = v1; ret1_pc_i = pc1; ret1_opcode_i = pc1 ^ 32'h5A000000;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset;
      accept_i = 1;
      do_reset();
      vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", valid_o); end
      vectors++; if (level_o !== 4'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level_o); end
      vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b want 0", overflow_o); end
      vectors++; if (drop_count_o !== 16'd0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", drop_count_o); end
      tick(); // accept while empty must be ignored
      vectors++; if (level_o !== 4'd0 || valid_o !== 1'b0) begin miscompares++; $display("FAIL accept_empty level %0d valid %0b want 0 0", level_o, valid_o); end
   endtask

   task automatic test_single;
      accept_i = 1;
      ret0_valid_i = 1; ret0_pc_i = 32'h80000000; ret0_opcode_i = 32'h00000013;
      tick();
      idle_inputs();
      vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h80000000 || opcode_o !== 32'h00000013) begin
         miscompares++; $display("FAIL single_slot0 valid %0b pc %h op %h want 1 80000000 00000013", valid_o, pc_o, opcode_o); end
      ret1_valid_i = 1; ret1_pc_i = 32'h80000004; ret1_opcode_i = 32'h00100093;
      tick();
      idle_inputs();
      vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h80000004 || opcode_o !== 32'h00100093) begin
         miscompares++; $display("FAIL single_slot1 valid %0b pc %h op %h want 1 80000004 00100093", valid_o, pc_o, opcode_o); end
      vectors++; if (level_o !== 4'd1) begin miscompares++; $display("FAIL single_level1 got %0d want 1", level_o); end
      tick();
      vectors++; if (level_o !== 4'd0 || valid_o !== 1'b0) begin miscompares++; $display("FAIL single_drain level %0d valid %0b want 0 0", level_o, valid_o); end
   endtask

   task automatic test_dual;
      accept_i = 1;
      retire(1, 32'h100, 1, 32'h104);
      vectors++; if (pc_o !== 32'h100 || level_o !== 4'd2) begin miscompares++; $display("FAIL dual_first pc %h level %0d want 100 2", pc_o, level_o); end
      tick();
      vectors++; if (pc_o !== 32'h104 || level_o !== 4'd1) begin miscompares++; $display("FAIL dual_second pc %h level %0d want 104 1", pc_o, level_o); end
      tick();
      vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL dual_drain valid %0b want 0", valid_o); end
   endtask

   task automatic test_fill_overflow;
      do_reset();
      accept_i = 0;
      for (int k = 0; k < 4; k++) retire(1, 32'h200 + 8*k, 1, 32'h204 + 8*k);
      vectors++; if (level_o !== 4'd8 || overflow_o !== 1'b0) begin miscompares++; $display("FAIL fill_level level %0d ovf %0b want 8 0", level_o, overflow_o); end
      vectors++; if (drop_count_o !== 16'd0) begin miscompares++; $display("FAIL fill_nodrop got %0d want 0", drop_count_o); end
      retire(1, 32'h220, 1, 32'h224);
      vectors++; if (level_o !== 4'd8 || overflow_o !== 1'b1) begin miscompares++; $display("FAIL full_drop level %0d ovf %0b want 8 1", level_o, overflow_o); end
      vectors++; if (drop_count_o !== DROP2) begin miscompares++; $display("FAIL full_dropcnt got %0d want %0d", drop_count_o, DROP2); end
      vectors++; if (pc_o !== 32'h200) begin miscompares++; $display("FAIL full_head pc %h want 200", pc_o); end
   endtask

   task automatic test_partial_drop;
      do_reset();
      accept_i = 0;
      for (int k = 0; k < 3; k++) retire(1, 32'h400 + 8*k, 1, 32'h404 + 8*k);
      retire(1, 32'h418, 0, 32'h0);
      vectors++; if (level_o !== 4'd7) begin miscompares++; $display("FAIL partial_setup level %0d want 7", level_o); end
      retire(1, 32'h41C, 1, 32'h420);
      vectors++; if (level_o !== 4'd7 || overflow_o !== 1'b1) begin miscompares++; $display("FAIL partial_atomic level %0d ovf %0b want 7 1", level_o, overflow_o); end
      vectors++; if (drop_count_o !== DROP2) begin miscompares++; $display("FAIL partial_dropcnt got %0d want %0d", drop_count_o, DROP2); end
      retire(0, 32'h0, 1, 32'h424);
      vectors++; if (level_o !== 4'd8 || drop_count_o !== DROP2) begin miscompares++; $display("FAIL partial_single level %0d drop %0d want 8 %0d", level_o, drop_count_o, DROP2); end
   endtask

   // Retire events every third cycle alternate single/dual; accept toggles 1,0,1,0...
   task automatic test_wrap_backpressure;
      logic [31:0] q[$];
      logic [31:0] next_pc;
      logic [31:0] prev_pc;
      logic        prev_stall;
      int          popped;
      int          ev;
      do_reset();
      next_pc = 32'h1000; prev_stall = 0; prev_pc = '0; popped = 0; ev = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         idle_inputs();
         accept_i = (cyc % 2 == 0) || (cyc >= 60);
         if (cyc % 3 == 0 && ev < 20) begin
            if (ev % 2 == 0) begin
               ret0_valid_i = 1; ret0_pc_i = next_pc; ret0_opcode_i = next_pc ^ 32'h5A000000;
               next_pc += 4;
            end else begin
               ret0_valid_i = 1; ret0_pc_i = next_pc;     ret0_opcode_i = next_pc ^ 32'h5A000000;
               ret1_valid_i = 1; ret1_pc_i = next_pc + 4; ret1_opcode_i = (next_pc + 4) ^ 32'h5A000000;
               next_pc += 8;
            end
            ev++;
         end
         if (prev_stall) begin
            vectors++; if (pc_o !== prev_pc) begin miscompares++; $display("FAIL wrap_stable cyc %0d pc %h want %h", cyc, pc_o, prev_pc); end
         end
         prev_stall = valid_o && !accept_i;
         prev_pc    = pc_o;
         if (valid_o && accept_i) begin
            vectors++;
            if (q.size() == 0 || pc_o !== q[0] || opcode_o !== (q[0] ^ 32'h5A000000)) begin
               miscompares++; $display("FAIL wrap_order cyc %0d pc %h op %h want %h", cyc, pc_o, opcode_o, (q.size() != 0) ? q[0] : 32'hX);
            end
            if (q.size() != 0) void'(q.pop_front());
            popped++;
         end
         if (ret0_valid_i) q.push_back(ret0_pc_i);
         if (ret1_valid_i) q.push_back(ret1_pc_i);
         tick();
         vectors++; if (level_o !== 4'(q.size())) begin miscompares++; $display("FAIL wrap_level cyc %0d got %0d want %0d", cyc, level_o, q.size()); end
      end
      idle_inputs();
      vectors++; if (popped != 30 || overflow_o !== 1'b0) begin miscompares++; $display("FAIL wrap_total popped %0d ovf %0b want 30 0", popped, overflow_o); end
   endtask

   task automatic test_reset_midstream;
      do_reset();
      accept_i = 0;
      retire(1, 32'h500, 1, 32'h504);
      retire(1, 32'h508, 1, 32'h50C);
      retire(1, 32'h510, 0, 32'h0);
      vectors++; if (level_o !== 4'd5) begin miscompares++; $display("FAIL mid_setup level %0d want 5", level_o); end
      rst_i = 1;
      ret0_valid_i = 1; ret0_pc_i = 32'h600; ret1_valid_i = 1; ret1_pc_i = 32'h604;
      tick();
      rst_i = 0; idle_inputs();
      vectors++; if (valid_o !== 1'b0 || level_o !== 4'd0 || overflow_o !== 1'b0 || drop_count_o !== 16'd0) begin
         miscompares++; $display("FAIL mid_reset valid %0b level %0d ovf %0b drop %0d want 0 0 0 0", valid_o, level_o, overflow_o, drop_count_o); end
      retire(1, 32'h700, 0, 32'h0);
      vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h700 || level_o !== 4'd1) begin
         miscompares++; $display("FAIL mid_restart valid %0b pc %h level %0d want 1 700 1", valid_o, pc_o, level_o); end
   endtask

   initial begin
      rst_i = 1; accept_i = 0;
      idle_inputs();
      test_reset();
      test_single();
      test_dual();
      test_fill_overflow();
      test_partial_drop();
      test_wrap_backpressure();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
